// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern player.
// Mode and direction enums plus the default PWM width.
package led_pkg;

    localparam int PWM_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_SPARKLE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: duty register swapped only at period end,
// registered compare against the shared counter.
module led_pwm_channel #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    input  logic             wrap_i,
    input  logic [PWM_W-1:0] duty_nxt_i,
    output logic             led_o
);

    logic [PWM_W-1:0] duty_q;
    logic             led_q;

    // Take the new duty only on the last count so periods stay whole.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
        end else if (wrap_i) begin
            duty_q <= duty_nxt_i;
        end
    end

    // Registered compare keeps the pin free of combinational glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= 1'b0;
        end else begin
            led_q <= (pwm_cnt_i < duty_q);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pattern_player.sv
// Pattern FSM (OFF/SOLID/BREATHE/SPARKLE) driving NUM_CH PWM channels.
// Define GAMMA_CORR_EN to square the duty for a perceptually linear fade.
module led_pattern_player
    import led_pkg::*;
#(
    parameter int PWM_W  = PWM_W_DEF,
    parameter int NUM_CH = 3,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_tick,
    input  logic              mode_tick,
    input  logic [7:0]        rand_num,
    input  logic [1:0]        mode_sel,
    input  logic              mode_load,
    output logic [NUM_CH-1:0] led_out,
    output logic [1:0]        mode_q
);

    localparam int W1 = PWM_W + 1;
    localparam logic [PWM_W-1:0] MAXV   = '1;
    localparam logic [PWM_W-1:0] STEP_N = PWM_W'(STEP);
    localparam logic [W1-1:0]    STEP_X = W1'(STEP);

    mode_e             mode_cur_q, mode_cur_d;
    dir_e              dir_q, dir_d;
    logic [PWM_W-1:0]  level_q, level_d;
    logic [NUM_CH-1:0] colour_q, colour_d;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic              wrap;

    logic [W1-1:0]     up_sum;
    logic [PWM_W-1:0]  up_sat;
    logic [PWM_W-1:0]  dn_val;
    logic [NUM_CH-1:0] seed;

    logic [PWM_W-1:0]  duty_nxt [NUM_CH];

    assign wrap   = (pwm_cnt_q == MAXV);
    assign mode_q = mode_cur_q;

    // Free-running PWM counter shared by every channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // Mode, level, direction and colour state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_cur_q <= MODE_OFF;
            dir_q      <= DIR_UP;
            level_q    <= '0;
            colour_q   <= '0;
        end else begin
            mode_cur_q <= mode_cur_d;
            dir_q      <= dir_d;
            level_q    <= level_d;
            colour_q   <= colour_d;
        end
    end

    // Saturating step helpers and the non-zero sparkle seed.
    always_comb begin
        up_sum = {1'b0, level_q} + STEP_X;
        up_sat = up_sum[PWM_W] ? MAXV : up_sum[PWM_W-1:0];
        dn_val = (level_q < STEP_N) ? '0 : (level_q - STEP_N);
        seed   = rand_num[NUM_CH-1:0];
        if (seed == '0) begin
            seed = NUM_CH'(1);
        end
    end

    // Next state; a mode load restarts the pattern and masks ticks.
    always_comb begin
        mode_cur_d = mode_cur_q;
        dir_d      = dir_q;
        level_d    = level_q;
        colour_d   = colour_q;
        if (mode_load) begin
            mode_cur_d = mode_e'(mode_sel);
            dir_d      = DIR_UP;
            level_d    = '0;
            colour_d   = '0;
        end else begin
            case (mode_cur_q)
                MODE_BREATHE: begin
                    if (step_tick) begin
                        if (dir_q == DIR_UP) begin
                            level_d = up_sat;
                            if (up_sat == MAXV) begin
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            level_d = dn_val;
                            if (dn_val == '0) begin
                                dir_d = DIR_UP;
                            end
                        end
                    end
                end
                MODE_SPARKLE: begin
                    if (mode_tick) begin
                        colour_d = seed;
                        level_d  = MAXV;
                    end else if (step_tick) begin
                        level_d = dn_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GAMMA_CORR_EN
    function automatic logic [PWM_W-1:0] shape(
        input logic [PWM_W-1:0] v
    );
        logic [2*PWM_W-1:0] sq;
        sq = {{PWM_W{1'b0}}, v} * {{PWM_W{1'b0}}, v};
        return (v == MAXV) ? MAXV : sq[2*PWM_W-1:PWM_W];
    endfunction
`else
    function automatic logic [PWM_W-1:0] shape(
        input logic [PWM_W-1:0] v
    );
        return v;
    endfunction
`endif

    // Per-channel target duty derived from the active pattern.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_nxt[i] = '0;
            case (mode_cur_q)
                MODE_SOLID:   duty_nxt[i] = MAXV;
                MODE_BREATHE: duty_nxt[i] = shape(level_q);
                MODE_SPARKLE: begin
                    if (colour_q[i]) begin
                        duty_nxt[i] = shape(level_q);
                    end
                end
                default:      duty_nxt[i] = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .pwm_cnt_i  (pwm_cnt_q),
            .wrap_i     (wrap),
            .duty_nxt_i (duty_nxt[g]),
            .led_o      (led_out[g])
        );
    end

endmodule
